traffic_phase_ctrl: RTL
=======================

# traffic_phase_ctrl

Phase controller that shares the four-way intersection between the north/south axis (detect_ns, detect_sn) and the east/west axis (detect_ew, detect_we). It grants green to one axis at a time, with yellow and all-red clearance intervals. Dwell times are counted in 1 ms ticks from the existing clockdiv. Its light outputs drive the signal heads, and its phase code feeds the visualization path alongside the car counters.

## Interface
- MIN_GREEN, 5000: minimum green dwell, in ticks (≥1).
- MAX_GREEN, 30000: maximum green dwell while the other axis waits, in ticks (> MIN_GREEN).
- YELLOW, 3000: yellow dwell, in ticks (≥1).
- ALL_RED, 1000: all-red clearance dwell, in ticks (≥1).
- TW, 16: timer width; must hold MAX_GREEN.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- tick  in  1  one-cycle enable pulse (1 ms from clockdiv); the only event that advances timers.
- detect_ns, detect_sn, detect_ew, detect_we  in  1 each  car-present levels, active-high, synchronous to clock.
- light_ns  out  3  {red, yellow, green} one-hot for the N/S heads.
- light_ew  out  3  {red, yellow, green} one-hot for the E/W heads.
- phase  out  3  current state code.
- green_start  out  1  one-cycle pulse on entry to either GREEN state.

## Operation
- States: NS_GREEN, NS_YELLOW, RED_TO_EW, EW_GREEN, EW_YELLOW, RED_TO_NS. The cycle runs in that order and never skips a state.
- Lights by state:
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - RED_TO_*: both 100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - No state may show green or yellow on both axes.
- Demand:
  - dem_ns = detect_ns|detect_sn; dem_ew = detect_ew|detect_we.
  - wait_ns is set on any cycle with dem_ns=1 while N/S is not green, and cleared on entry to NS_GREEN. wait_ew is symmetric.
- Timer:
  - Cleared to 0 on every state entry.
  - Increments on each tick and saturates at 2^TW−1.
  - Ticks reaching the elapsed count k means timer==k−1 with tick=1.
- GREEN (own axis X, other axis Y) is left for X_YELLOW on a tick when wait_Y=1 and elapsed ≥ MIN_GREEN and either:
  - dem_X=0 (gap-out), or
  - elapsed ≥ MAX_GREEN (max-out).
- With wait_Y=0, GREEN holds indefinitely; the timer saturates.
- YELLOW exits after exactly YELLOW ticks; RED_TO_* exits after exactly ALL_RED ticks.
- Outputs are registered and decoded from the state register; they have no combinational path from inputs.
- Reset values:
  - state=NS_GREEN, timer=0, wait_ns=wait_ew=0.
  - light_ns=001, light_ew=100, phase=NS_GREEN code, green_start=0.

## Timing
- A transition takes effect on the clock edge where the qualifying tick is sampled. Outputs reflect the new state the same edge.
- A detector asserted in the same cycle as a qualifying tick is counted for wait_* that cycle, giving a one-cycle path from demand to decision.
- green_start is high for the single cycle after entry to NS_GREEN or EW_GREEN. It is not asserted out of reset.
- Simultaneous demand on both axes: the current green axis keeps priority until gap-out or max-out. No starvation: the waiting axis is served within MAX_GREEN+YELLOW+ALL_RED ticks.
- Detector activity during YELLOW or RED_TO_* cannot shorten or extend those states.
- Reset asserted mid-phase: state returns to NS_GREEN asynchronously and all waits are dropped. After release, operation resumes at the next clock.
- tick=0 freezes the timer; the state can change only on tick cycles.

## Structure
- traffic_pkg (shared header) holds:
  - the state codes (3-bit localparams),
  - the light encodings RED=3'b100, YEL=3'b010, GRN=3'b001,
  - the default dwell constants.
- One sub-module, phase_timer, provides tick counting with clear, saturation, and the comparator outputs ge_min, ge_max, and done(len). The FSM and demand latches stay in traffic_phase_ctrl.
- The 1 ms tick comes from an external clockdiv instance and is not generated here.

## Test plan
All scenarios use MIN_GREEN=4, MAX_GREEN=10, YELLOW=2, ALL_RED=1, and tick held high every cycle.
- Reset, no detectors for 50 cycles -> stays NS_GREEN; light_ns=001, light_ew=100; green_start never pulses.
- Pulse detect_ew for 1 cycle at cycle 0 with N/S idle -> NS_YELLOW on the 4th tick. Then RED_TO_EW after 2 ticks, then EW_GREEN after 1 tick, with green_start high for 1 cycle.
- detect_ns held high and detect_we held high from reset -> N/S max-out: NS_GREEN lasts 10 ticks, then yellow (2) and all-red (1), then EW_GREEN.
- Reset asserted for 1 cycle during EW_YELLOW -> outputs immediately ns=001, ew=100; wait flags are 0.
- tick toggled every 3rd cycle, detect_sn held and detect_ew pulsed once -> NS_GREEN holds for MAX_GREEN ticks (30 clocks) before yellow. Lights never conflict (asserted every cycle).
- Detector pulses injected only during NS_YELLOW -> yellow duration unchanged at 2 ticks, and EW is served next.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase controller: phase codes,
// signal-head encodings, default dwell times and a phase-to-lights decoder.
package traffic_pkg;

    // Phase codes as seen on the phase output and by the visualization path
    localparam logic [2:0] PH_NS_GREEN  = 3'd0;
    localparam logic [2:0] PH_NS_YELLOW = 3'd1;
    localparam logic [2:0] PH_RED_TO_EW = 3'd2;
    localparam logic [2:0] PH_EW_GREEN  = 3'd3;
    localparam logic [2:0] PH_EW_YELLOW = 3'd4;
    localparam logic [2:0] PH_RED_TO_NS = 3'd5;

    typedef enum logic [2:0] {
        NS_GREEN  = PH_NS_GREEN,
        NS_YELLOW = PH_NS_YELLOW,
        RED_TO_EW = PH_RED_TO_EW,
        EW_GREEN  = PH_EW_GREEN,
        EW_YELLOW = PH_EW_YELLOW,
        RED_TO_NS = PH_RED_TO_NS
    } phase_e;

    // Signal-head encodings, {red, yellow, green} one-hot
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Default dwell times in 1 ms ticks
    localparam int DEF_MIN_GREEN = 5000;
    localparam int DEF_MAX_GREEN = 30000;
    localparam int DEF_YELLOW    = 3000;
    localparam int DEF_ALL_RED   = 1000;
    localparam int DEF_TW        = 16;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lights_t;

    // Only one axis is ever away from red; unknown codes fall back to all-red.
    function automatic lights_t lights_for(input phase_e ph);
        lights_t l;
        l.ns = RED;
        l.ew = RED;
        case (ph)
            NS_GREEN:  l.ns = GRN;
            NS_YELLOW: l.ns = YEL;
            EW_GREEN:  l.ew = GRN;
            EW_YELLOW: l.ew = YEL;
            default:   l = '{ns: RED, ew: RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Dwell timer for the phase controller: counts ticks since the last state
// entry, saturates at all-ones, and compares the count against the green
// limits and a per-state dwell length.
module phase_timer #(
    parameter int TW        = 16,
    parameter int MIN_GREEN = 5000,
    parameter int MAX_GREEN = 30000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          clear,
    input  logic [TW-1:0] len,
    output logic          ge_min,
    output logic          ge_max,
    output logic          done
);

    // Comparisons are against count-1 because the deciding tick is the one
    // that would bring the elapsed count up to the limit.
    localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] SAT    = '1;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next count: clear on state entry, otherwise saturating tick increment
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (tick && (timer_q != SAT)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign ge_min = (timer_q >= MIN_M1);
    assign ge_max = (timer_q >= MAX_M1);
    assign done   = (timer_q == (len - TW'(1)));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-axis intersection phase controller. Serves N/S and E/W in a fixed
// six-phase cycle with yellow and all-red clearance, using latched demand
// so a brief car presence on the waiting axis is never forgotten.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW    = DEF_YELLOW,
    parameter int ALL_RED   = DEF_ALL_RED,
    parameter int TW        = DEF_TW
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       detect_ns,
    input  logic       detect_sn,
    input  logic       detect_ew,
    input  logic       detect_we,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [2:0] phase,
    output logic       green_start
);

    phase_e     state_q, state_d;
    logic       wait_ns_q, wait_ns_d;
    logic       wait_ew_q, wait_ew_d;
    logic [2:0] light_ns_q, light_ew_q, phase_q;
    logic       green_start_q;
    lights_t    lights_d;
    logic [2:0] phase_d;
    logic       green_start_d;

    logic          dem_ns, dem_ew;
    logic          wait_ns_eff, wait_ew_eff;
    logic          timer_clear;
    logic [TW-1:0] timer_len;
    logic          ge_min, ge_max, done;

    phase_timer #(
        .TW        (TW),
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .tick   (tick),
        .clear  (timer_clear),
        .len    (timer_len),
        .ge_min (ge_min),
        .ge_max (ge_max),
        .done   (done)
    );

    // Demand, effective waits, next phase, timer control and next outputs
    always_comb begin
        dem_ns = detect_ns | detect_sn;
        dem_ew = detect_ew | detect_we;

        // Include this cycle's demand so a car seen on the deciding tick counts
        wait_ns_eff = wait_ns_q | (dem_ns & (state_q != NS_GREEN));
        wait_ew_eff = wait_ew_q | (dem_ew & (state_q != EW_GREEN));

        timer_len = ((state_q == NS_YELLOW) || (state_q == EW_YELLOW))
                    ? TW'(YELLOW) : TW'(ALL_RED);

        state_d = state_q;
        unique case (state_q)
            NS_GREEN:  if (tick && wait_ew_eff && ge_min && (!dem_ns || ge_max))
                           state_d = NS_YELLOW;
            NS_YELLOW: if (tick && done) state_d = RED_TO_EW;
            RED_TO_EW: if (tick && done) state_d = EW_GREEN;
            EW_GREEN:  if (tick && wait_ns_eff && ge_min && (!dem_ew || ge_max))
                           state_d = EW_YELLOW;
            EW_YELLOW: if (tick && done) state_d = RED_TO_NS;
            RED_TO_NS: if (tick && done) state_d = NS_GREEN;
            default:   state_d = NS_GREEN;
        endcase

        timer_clear = (state_d != state_q);

        // A wait is satisfied when its axis turns green
        wait_ns_d = ((state_d == NS_GREEN) && (state_q != NS_GREEN)) ? 1'b0 : wait_ns_eff;
        wait_ew_d = ((state_d == EW_GREEN) && (state_q != EW_GREEN)) ? 1'b0 : wait_ew_eff;

        // Outputs are decoded from the next phase so they land with the state
        lights_d      = lights_for(state_d);
        phase_d       = state_d;
        green_start_d = ((state_d == NS_GREEN) || (state_d == EW_GREEN)) &&
                        (state_d != state_q);
    end

    // Phase register, demand latches and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= NS_GREEN;
            wait_ns_q     <= 1'b0;
            wait_ew_q     <= 1'b0;
            light_ns_q    <= GRN;
            light_ew_q    <= RED;
            phase_q       <= PH_NS_GREEN;
            green_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_ns_q     <= wait_ns_d;
            wait_ew_q     <= wait_ew_d;
            light_ns_q    <= lights_d.ns;
            light_ew_q    <= lights_d.ew;
            phase_q       <= phase_d;
            green_start_q <= green_start_d;
        end
    end

    assign light_ns    = light_ns_q;
    assign light_ew    = light_ew_q;
    assign phase       = phase_q;
    assign green_start = green_start_q;

endmodule
